// File: rtl/imm_pack.sv
// Two-stage immediate packer: merges an encoded immediate into a RISC-V style base word.
// Define IMM_PACK_RANGE_CHECK_EN to enable range/illegal-format checking and the error counter.
module imm_pack (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] BASE_INSTRUCTION,
  input  logic [31:0] IMMIDIATE,
  input  logic [2:0]  IMM_PICK,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] INSTRUCTION,
  output logic        IMM_ERROR,
  output logic [7:0]  ERR_COUNT
);

  localparam logic [2:0] PICK_I = 3'd0;
  localparam logic [2:0] PICK_S = 3'd1;
  localparam logic [2:0] PICK_U = 3'd2;
  localparam logic [2:0] PICK_B = 3'd3;
  localparam logic [2:0] PICK_J = 3'd4;

  logic        run_q;
  logic        s1_valid;
  logic        s1_err;
  logic [31:0] s1_base;
  logic [31:0] s1_imm;
  logic [2:0]  s1_pick;
  logic        s2_free;
  logic        s1_adv;
  logic        in_fire;
  logic        range_err;
  logic [31:0] merged;

  // Handshake: a transfer happens on a rising CLK edge where valid and ready are
  // both 1; a producer holds valid and data stable until the transfer occurs.
  assign s2_free  = !OUT_VALID || OUT_READY;
  assign s1_adv   = s1_valid && s2_free;
  assign IN_READY = run_q && (!s1_valid || s2_free);
  assign in_fire  = IN_VALID && IN_READY;

`ifdef IMM_PACK_RANGE_CHECK_EN
  logic hi11_same;
  logic hi12_same;
  logic hi20_same;

  assign hi11_same = (IMMIDIATE[31:11] == '0) || (IMMIDIATE[31:11] == '1);
  assign hi12_same = (IMMIDIATE[31:12] == '0) || (IMMIDIATE[31:12] == '1);
  assign hi20_same = (IMMIDIATE[31:20] == '0) || (IMMIDIATE[31:20] == '1);

  always_comb begin
    range_err = 1'b1;
    case (IMM_PICK)
      PICK_I, PICK_S: range_err = !hi11_same;
      PICK_U:         range_err = |IMMIDIATE[11:0];
      PICK_B:         range_err = IMMIDIATE[0] || !hi12_same;
      PICK_J:         range_err = IMMIDIATE[0] || !hi20_same;
      default:        range_err = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ERR_COUNT <= 8'd0;
    end else if (OUT_VALID && OUT_READY && IMM_ERROR && (ERR_COUNT != 8'hFF)) begin
      ERR_COUNT <= ERR_COUNT + 8'd1;
    end
  end
`else
  assign range_err = 1'b0;
  assign ERR_COUNT = 8'd0;
`endif

  // Out-of-range immediates still merge their truncated low bits.
  always_comb begin
    merged = s1_base;
    case (s1_pick)
      PICK_I: merged[31:20] = s1_imm[11:0];
      PICK_S: begin
        merged[31:25] = s1_imm[11:5];
        merged[11:7]  = s1_imm[4:0];
      end
      PICK_U: merged[31:12] = s1_imm[31:12];
      PICK_B: begin
        merged[31]    = s1_imm[12];
        merged[30:25] = s1_imm[10:5];
        merged[11:8]  = s1_imm[4:1];
        merged[7]     = s1_imm[11];
      end
      PICK_J: begin
        merged[31]    = s1_imm[20];
        merged[30:21] = s1_imm[10:1];
        merged[20]    = s1_imm[11];
        merged[19:12] = s1_imm[19:12];
      end
      default: merged = s1_base;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      run_q       <= 1'b0;
      s1_valid    <= 1'b0;
      s1_err      <= 1'b0;
      s1_base     <= 32'd0;
      s1_imm      <= 32'd0;
      s1_pick     <= 3'd0;
      OUT_VALID   <= 1'b0;
      INSTRUCTION <= 32'd0;
      IMM_ERROR   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_err   <= range_err;
        s1_base  <= BASE_INSTRUCTION;
        s1_imm   <= IMMIDIATE;
        s1_pick  <= IMM_PICK;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s1_adv) begin
        OUT_VALID   <= 1'b1;
        INSTRUCTION <= merged;
        IMM_ERROR   <= s1_err;
      end else if (OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
    end
  end

endmodule
